word_unpacker: RTL and testbench
================================

Name: word_unpacker

Overview:
- Reverse of the byte-to-word packer on the FIFO path.
- Accepts one 32-bit word from the FIFO side through a valid/ready handshake.
- Emits the word as a stream of 8-bit bytes, MSB byte first. This is the same byte order the packer builds words in, so packer-then-unpacker is lossless.
- Sits between the FIFO read side and the byte-wide transmit/APB-facing logic.

Parameters:
- BYTE_W, 8: width of one output byte.
- NBYTES, 4: bytes per word; word width is BYTE_W*NBYTES (32). NBYTES must be ≥2.

Ports:
- clk  input  1  single clock, rising edge.
- res_n  input  1  asynchronous, active-low reset.
- word_in  input  BYTE_W*NBYTES  word from the FIFO.
- word_valid  input  1  word_in is valid.
- word_ready  output  1  block can take a word this cycle.
- byte_out  output  BYTE_W  current byte.
- byte_valid  output  1  byte_out is valid.
- byte_ready  input  1  downstream takes byte_out this cycle.
- byte_last  output  1  byte_out is the final (LSB) byte of the current word.
- busy  output  1  a word is being unpacked.

Behaviour:
- Reset: asynchronous on res_n low. Clears the state, the holding register and the byte index.
  - Outputs in reset: byte_valid=0, byte_out=0, byte_last=0, busy=0, word_ready=0.
  - word_ready rises the first cycle after res_n deasserts.
- Word accept: occurs on a clock edge where word_valid && word_ready. The holding register loads word_in and the byte index is set to 0.
- Byte transfer: occurs on a clock edge where byte_valid && byte_ready.
- State machine, 2 states:
  - IDLE:
    - Outputs: byte_valid=0, busy=0, word_ready=1.
    - On word accept, go to SEND.
  - SEND:
    - byte_valid=1, busy=1.
    - byte_out = holding[(NBYTES-1-idx)*BYTE_W +: BYTE_W], driven from registers.
    - byte_last = (idx==NBYTES-1).
    - On a byte transfer with idx<NBYTES-1: idx increments.
    - On a byte transfer with idx==NBYTES-1:
      - If word_valid is high the same cycle, load the new word, set idx=0 and stay in SEND, giving back-to-back words with no bubble.
      - Otherwise go to IDLE.
- word_ready in SEND = byte_last && byte_ready (combinational). This is the only combinational path from input to output.
- Latency: the first byte is valid the cycle after the word is accepted. Sustained throughput with byte_ready held high is one byte per clock, and one word every NBYTES clocks.
- Backpressure: while byte_ready=0, byte_out, byte_valid and byte_last hold stable and idx does not change.
- In IDLE, byte_out keeps the last value shown; it is don't-care while byte_valid=0.
- word_in is ignored unless a word accept occurs. A change on word_in mid-word has no effect.
- Reset mid-word: the partial word is discarded; no further bytes are emitted after reset.
- Index width: $clog2(NBYTES) bits, no wrap beyond NBYTES-1.

Decomposition:
- Shared package (apb_pkg), holding:
  - BYTE_W and NBYTES defaults;
  - derived WORD_W;
  - the state enum {IDLE, SEND}.
- No sub-module; a single module with registered datapath and FSM.

Test Plan:
1. Reset, then word_valid=1 with word_in=32'hA1B2C3D4 and byte_ready=1 held → byte_out sequence A1,B2,C3,D4 on 4 consecutive cycles. byte_last is high only on D4. word_ready pulses high in the D4 cycle.
2. Back-to-back: words 32'h01020304 then 32'h05060708 both presented, byte_ready=1 → 8 contiguous bytes 01..08 with no idle cycle, and byte_last on 04 and 08.
3. Backpressure: word 32'hDEADBEEF with byte_ready toggling 1,0,0,1,0,1,1 → bytes DE,AD,BE,EF each held stable while byte_ready=0. Exactly 4 transfers, and busy falls the cycle after the EF transfer.
4. Reset mid-word: word 32'h11223344, pull res_n low after the 22 transfer → byte_valid drops immediately (asynchronously) and busy=0. After release, no 33/44 appears and word_ready=1.
5. Input hold while busy: change word_in to 32'hFFFFFFFF during the SEND of 32'h55667788 with word_valid=0 → output is still 55,66,77,88, then IDLE.
6. Loopback with the packer: random stream of 64 bytes → packer → unpacker → output byte stream equals the input stream in order.

Source files
------------

// File: rtl/apb_pkg.sv
// apb_pkg: shared widths and state encoding for the byte/word FIFO path
package apb_pkg;
  localparam int BYTE_W = 8;
  localparam int NBYTES = 4;
  localparam int WORD_W = BYTE_W * NBYTES;
  typedef enum logic {IDLE, SEND} state_t;
endpackage

// File: rtl/word_unpacker.sv
// word_unpacker: splits each FIFO word into a stream of bytes, MSB byte first
module word_unpacker
  import apb_pkg::*;
#(
  parameter int BYTE_W = apb_pkg::BYTE_W,
  parameter int NBYTES = apb_pkg::NBYTES
) (
  input  logic                     clk,
  input  logic                     res_n,
  input  logic [BYTE_W*NBYTES-1:0] word_in,
  input  logic                     word_valid,
  output logic                     word_ready,
  output logic [BYTE_W-1:0]        byte_out,
  output logic                     byte_valid,
  input  logic                     byte_ready,
  output logic                     byte_last,
  output logic                     busy
);
  localparam int IW = $clog2(NBYTES);
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);
  state_t state, state_d;
  logic [BYTE_W*NBYTES-1:0] hold, hold_d;
  logic [IW-1:0] idx, idx_d;
  logic armed, accept, xfer;
  always_ff @(posedge clk or negedge res_n)
    if (!res_n) begin
      state <= IDLE;
      hold  <= '0;
      idx   <= '0;
      armed <= 1'b0;
    end else begin
      state <= state_d;
      hold  <= hold_d;
      idx   <= idx_d;
      armed <= 1'b1;
    end
  assign busy       = state == SEND;
  assign byte_valid = busy;
  assign byte_last  = busy && idx == LAST;
  assign byte_out   = hold[(LAST - idx)*BYTE_W +: BYTE_W];
  // armed keeps word_ready low until the first edge after reset release
  assign word_ready = busy ? byte_last && byte_ready : armed;
  assign accept     = word_valid && word_ready;
  assign xfer       = byte_valid && byte_ready;
  always_comb begin
    state_d = state;
    hold_d  = hold;
    idx_d   = idx;
    if (accept) begin
      state_d = SEND;
      hold_d  = word_in;
      idx_d   = '0;
    end else if (xfer) begin
      state_d = byte_last ? IDLE : SEND;
      idx_d   = byte_last ? idx : idx + 1'b1;
    end
  end
endmodule

// File: tb/tb_word_unpacker.sv
// tb_word_unpacker: scoreboard bench for the word-to-byte unpacker
module tb_word_unpacker;
  logic        clk = 1'b0;
  logic        res_n = 1'b0;
  logic [31:0] word_in = '0;
  logic        word_valid = 1'b0;
  logic        word_ready;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_ready = 1'b0;
  logic        byte_last;
  logic        busy;
  logic [8:0]  q[$];
  logic [8:0]  exp_e;
  int          errors = 0;
  int          checks = 0;
  int          rx = 0;
  logic        rand_bp = 1'b0;

  word_unpacker dut (
    .clk(clk), .res_n(res_n), .word_in(word_in), .word_valid(word_valid),
    .word_ready(word_ready), .byte_out(byte_out), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .byte_last(byte_last), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rand_bp) begin
    #1;
    byte_ready = 1'($urandom_range(0, 1));
  end

  always @(negedge clk) if (res_n && byte_valid && byte_ready) begin
    rx++;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: unexpected byte %h last=%b", byte_out, byte_last);
    end else begin
      exp_e = q.pop_front();
      if ({byte_last, byte_out} !== exp_e) begin
        errors++;
        $display("FAIL scoreboard: got last=%b byte=%h expected last=%b byte=%h",
                 byte_last, byte_out, exp_e[8], exp_e[7:0]);
      end
    end
  end

  task automatic push_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) q.push_back({i == 3, w[31-8*i -: 8]});
  endtask

  task automatic send_word(input logic [31:0] w);
    int n = 0;
    #1;
    word_in = w;
    word_valid = 1'b1;
    while (!word_ready && n < 200) begin
      @(posedge clk); #2;
      n++;
    end
    checks++;
    if (!word_ready) begin
      errors++;
      $display("FAIL send_word: word_ready never rose for %h", w);
    end
    @(posedge clk); #1;
    word_valid = 1'b0;
  endtask

  task automatic test_reset();
    res_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({byte_valid, byte_out, byte_last, busy, word_ready} !== 12'h0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b b=%h l=%b busy=%b wr=%b expected all 0",
               byte_valid, byte_out, byte_last, busy, word_ready);
    end
    @(posedge clk); #1;
    res_n = 1'b1;
    #1;
    checks++;
    if (word_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: word_ready=%b expected 0 before first edge", word_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (word_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: word_ready=%b expected 1", word_ready);
    end
  endtask

  task automatic test_single();
    byte_ready = 1'b1;
    push_word(32'hA1B2C3D4);
    send_word(32'hA1B2C3D4);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({byte_valid, byte_last, word_ready} !== {1'b1, i == 3, i == 3}) begin
        errors++;
        $display("FAIL single_%0d: got v=%b l=%b wr=%b expected v=1 l=%b wr=%b",
                 i, byte_valid, byte_last, word_ready, i == 3, i == 3);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++;
    if ({byte_valid, busy, word_ready} !== 3'b001) begin
      errors++;
      $display("FAIL single_idle: got v=%b busy=%b wr=%b expected 0 0 1",
               byte_valid, busy, word_ready);
    end
  endtask

  task automatic test_back_to_back();
    byte_ready = 1'b1;
    push_word(32'h01020304);
    send_word(32'h01020304);
    word_in = 32'h05060708;
    word_valid = 1'b1;
    push_word(32'h05060708);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if ({byte_valid, byte_last} !== {1'b1, i % 4 == 3}) begin
        errors++;
        $display("FAIL b2b_%0d: got v=%b l=%b expected v=1 l=%b",
                 i, byte_valid, byte_last, i % 4 == 3);
      end
      @(posedge clk); #1;
      if (i == 3) word_valid = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_backpressure();
    logic [6:0] p = 7'b1101001;
    logic [7:0] prev = '0;
    int xfers = 0;
    byte_ready = 1'b1;
    push_word(32'hDEADBEEF);
    send_word(32'hDEADBEEF);
    for (int i = 0; i < 7; i++) begin
      byte_ready = p[i];
      @(negedge clk);
      if (byte_valid && byte_ready) xfers++;
      checks++;
      if (i > 0 && !p[i-1] && byte_out !== prev) begin
        errors++;
        $display("FAIL bp_hold_%0d: byte_out=%h expected %h", i, byte_out, prev);
      end
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL bp_busy_%0d: busy=%b expected 1", i, busy);
      end
      prev = byte_out;
      @(posedge clk); #1;
    end
    byte_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || xfers != 4) begin
      errors++;
      $display("FAIL bp_done: busy=%b xfers=%0d expected busy=0 xfers=4", busy, xfers);
    end
  endtask

  task automatic test_reset_mid_word();
    byte_ready = 1'b1;
    push_word(32'h11223344);
    send_word(32'h11223344);
    repeat (2) begin
      @(posedge clk); #1;
    end
    res_n = 1'b0;
    #1;
    checks++;
    if ({byte_valid, busy, word_ready} !== 3'b000) begin
      errors++;
      $display("FAIL mid_reset: got v=%b busy=%b wr=%b expected 0 0 0",
               byte_valid, busy, word_ready);
    end
    q.delete();
    @(posedge clk); #1;
    res_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({byte_valid, word_ready} !== 2'b01) begin
        errors++;
        $display("FAIL mid_after_%0d: got v=%b wr=%b expected v=0 wr=1",
                 i, byte_valid, word_ready);
      end
    end
  endtask

  task automatic test_input_hold();
    byte_ready = 1'b1;
    push_word(32'h55667788);
    send_word(32'h55667788);
    word_in = 32'hFFFFFFFF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (byte_valid !== 1'b1) begin
        errors++;
        $display("FAIL hold_%0d: byte_valid=%b expected 1", i, byte_valid);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL hold_idle: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_loopback();
    logic [7:0] src[64];
    int n = 0;
    int rx0 = rx;
    for (int i = 0; i < 64; i++) src[i] = 8'($urandom);
    rand_bp = 1'b1;
    for (int w = 0; w < 16; w++) begin
      for (int b = 0; b < 4; b++) q.push_back({b == 3, src[4*w+b]});
      send_word({src[4*w], src[4*w+1], src[4*w+2], src[4*w+3]});
    end
    while (q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    rand_bp = 1'b0;
    @(posedge clk); #1;
    byte_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (q.size() != 0 || rx - rx0 != 64) begin
      errors++;
      $display("FAIL loopback: left=%0d received=%0d expected left=0 received=64",
               q.size(), rx - rx0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_word();
    test_input_hold();
    test_loopback();
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
